uart_rx_core: RTL and testbench

Synthesizable UART receiver that is the receive end of the serial link exercised by the device0/device1 agents in `hdl_top`. It synchronizes the `rx_i` line, oversamples it 16x, validates the start bit, and deframes 5–8 data bits with optional parity and 1 or 2 stop bits. Each received character is presented on a valid/ready holding register with parity, framing and overrun status.

---
 rtl/uart_rx_pkg.sv | 35 +++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_core.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM states, character-length
// encoding and oversampling constants.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2
   } rx_state_t;

   localparam logic [1:0] DBITS_5 = 2'b00;
   localparam logic [1:0] DBITS_6 = 2'b01;
   localparam logic [1:0] DBITS_7 = 2'b10;
   localparam logic [1:0] DBITS_8 = 2'b11;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   // Index of the final data bit for a given character-length code.
   function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
      logic [2:0] idx;
      case (data_bits)
         DBITS_5: idx = 3'd4;
         DBITS_6: idx = 3'd5;
         DBITS_7: idx = 3'd6;
         DBITS_8: idx = 3'd7;
         default: idx = 3'd7;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one tick every DIVISOR clocks, held off while restart
// is asserted so the first tick lands DIVISOR clocks after restart drops.
module uart_baud_tick #(
   parameter int DIVISOR = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam logic [15:0] RELOAD = 16'(DIVISOR - 1);

   logic [15:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= RELOAD;
      end else if (restart || cnt == 16'd0) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - 16'd1;
      end
   end

   assign tick = (cnt == 16'd0) && !restart;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop input sync, 16x oversampled deframing, valid/ready
// holding register with parity/framing status and overrun pulse.
//   state     | meaning
//   ST_IDLE   | line idle, waiting for falling edge
//   ST_START  | validating start bit at mid-bit
//   ST_DATA   | shifting data bits LSB first
//   ST_PARITY | sampling parity bit
//   ST_STOP1  | sampling first stop bit
//   ST_STOP2  | sampling second stop bit
module uart_rx_core
   import uart_rx_pkg::*;
#(
   parameter int DIVISOR = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   input  logic [1:0] data_bits_i,
   input  logic       parity_en_i,
   input  logic       parity_odd_i,
   input  logic       stop2_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       busy_o
);

   localparam int OS_W = $clog2(OVERSAMPLE);

   rx_state_t       state;
   logic            rx_meta, rx_s, rx_q;
   logic            fall, tick, sample, restart, accept, complete, frame_fin;
   logic [OS_W-1:0] os_cnt;
   logic [2:0]      bit_cnt, last_bit;
   logic [7:0]      shift;
   logic            par_en, par_odd, stop2, par_err, stop_err;
   logic [7:0]      data_q;
   logic            valid_q, perr_q, ferr_q, overrun_q, busy_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_q    <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
         rx_q    <= rx_s;
      end
   end

   assign fall    = rx_q & ~rx_s;
   assign restart = (state == ST_IDLE);

   uart_baud_tick #(.DIVISOR(DIVISOR)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         os_cnt <= '0;
      end else if (restart) begin
         os_cnt <= '0;
      end else if (tick) begin
         os_cnt <= os_cnt + 1'b1;
      end
   end

   assign sample = tick && (os_cnt == OS_W'(MID_SAMPLE));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         busy_q   <= 1'b0;
         bit_cnt  <= '0;
         last_bit <= '0;
         shift    <= '0;
         par_en   <= 1'b0;
         par_odd  <= 1'b0;
         stop2    <= 1'b0;
         par_err  <= 1'b0;
         stop_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fall) begin
                  state  <= ST_START;
                  busy_q <= 1'b1;
               end
            end
            ST_START: begin
               if (sample) begin
                  if (rx_s) begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     state    <= ST_DATA;
                     bit_cnt  <= '0;
                     shift    <= '0;
                     par_err  <= 1'b0;
                     stop_err <= 1'b0;
                     last_bit <= last_bit_idx(data_bits_i);
                     par_en   <= parity_en_i;
                     par_odd  <= parity_odd_i;
                     stop2    <= stop2_i;
                  end
               end
            end
            ST_DATA: begin
               if (sample) begin
                  shift[bit_cnt] <= rx_s;
                  if (bit_cnt == last_bit) begin
                     state <= par_en ? ST_PARITY : ST_STOP1;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (sample) begin
                  par_err <= (^shift) ^ rx_s ^ par_odd;
                  state   <= ST_STOP1;
               end
            end
            ST_STOP1: begin
               if (sample) begin
                  stop_err <= ~rx_s;
                  if (stop2) begin
                     state <= ST_STOP2;
                  end else begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                  end
               end
            end
            ST_STOP2: begin
               if (sample) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Completion is the mid-sample of the last stop bit; the FSM leaves on the same edge.
   assign complete  = sample && ((state == ST_STOP1 && !stop2) || state == ST_STOP2);
   assign frame_fin = (state == ST_STOP2) ? (stop_err | ~rx_s) : ~rx_s;
   assign accept    = valid_q & rx_ready_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (complete) begin
            if (!valid_q || accept) begin
               data_q  <= shift;
               perr_q  <= par_err;
               ferr_q  <= frame_fin;
               valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (accept) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_data_o    = data_q;
   assign rx_valid_o   = valid_q;
   assign parity_err_o = perr_q;
   assign frame_err_o  = ferr_q;
   assign overrun_o    = overrun_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: table-driven frames feed a scoreboard,
// plus hand sequences for false start, break, overrun and mid-frame reset.
module tb_uart_rx_core;

   localparam int DIV = 4;
   localparam int BIT = 16 * DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_i;
   logic [1:0] data_bits;
   logic       parity_en, parity_odd, stop2;
   logic [7:0] rx_data_o;
   logic       rx_valid_o, rx_ready_i;
   logic       parity_err_o, frame_err_o, overrun_o, busy_o;

   uart_rx_core #(.DIVISOR(DIV)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (rx_i),
      .data_bits_i  (data_bits),
      .parity_en_i  (parity_en),
      .parity_odd_i (parity_odd),
      .stop2_i      (stop2),
      .rx_data_o    (rx_data_o),
      .rx_valid_o   (rx_valid_o),
      .rx_ready_i   (rx_ready_i),
      .parity_err_o (parity_err_o),
      .frame_err_o  (frame_err_o),
      .overrun_o    (overrun_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [1:0] dbits;
      logic       pen, podd, s2, pflip, st1, st2;
      logic [7:0] exp_data;
      logic       exp_perr, exp_ferr;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       perr, ferr;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[11];
   int   checks = 0;
   int   errors = 0;
   int   valid_hi = 0;
   int   ovr_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: consume on valid&ready and compare against the scoreboard head.
   always @(negedge clk) begin
      if (rst) begin
         if (rx_valid_o) valid_hi++;
         if (overrun_o)  ovr_cnt++;
         if (rx_valid_o && rx_ready_i) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_char actual=%0h required=none", rx_data_o);
            end else begin
               mon_e = sb.pop_front();
               chk("rx_data", {24'd0, rx_data_o}, {24'd0, mon_e.data});
               chk("parity_err", {31'd0, parity_err_o}, {31'd0, mon_e.perr});
               chk("frame_err", {31'd0, frame_err_o}, {31'd0, mon_e.ferr});
            end
         end
      end
   end

   task automatic bit_out(input logic v);
      @(posedge clk);
      #1 rx_i = v;
      repeat (BIT - 1) @(posedge clk);
   endtask

   task automatic set_cfg(input logic [1:0] db, input logic pen, input logic podd, input logic s2);
      data_bits  = db;
      parity_en  = pen;
      parity_odd = podd;
      stop2      = s2;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] db, input logic pen,
                             input logic podd, input logic s2, input logic pflip,
                             input logic st1, input logic st2);
      int   n;
      logic p;
      n = 5 + int'(db);
      p = podd;
      for (int i = 0; i < n; i++) p = p ^ d[i];
      if (pflip) p = ~p;
      bit_out(1'b0);
      for (int i = 0; i < n; i++) bit_out(d[i]);
      if (pen) bit_out(p);
      bit_out(st1);
      if (s2) bit_out(st2);
      bit_out(1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          data   db     pen   podd  s2    pflip st1   st2   exp    perr  ferr
      vecs[0]  = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1]  = '{8'h41, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
      vecs[2]  = '{8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
      vecs[3]  = '{8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
      vecs[4]  = '{8'h15, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0};
      vecs[5]  = '{8'h2A, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0};
      vecs[6]  = '{8'hFF, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[7]  = '{8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0};
      vecs[8]  = '{8'hC3, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0};
      vecs[9]  = '{8'h0A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0A, 1'b0, 1'b1};
      vecs[10] = '{8'h6D, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h6D, 1'b0, 1'b1};

      rst        = 1'b0;
      rx_i       = 1'b1;
      rx_ready_i = 1'b1;
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("reset_data", {24'd0, rx_data_o}, 32'd0);
      chk("reset_valid", {31'd0, rx_valid_o}, 32'd0);
      chk("reset_perr", {31'd0, parity_err_o}, 32'd0);
      chk("reset_ferr", {31'd0, frame_err_o}, 32'd0);
      chk("reset_overrun", {31'd0, overrun_o}, 32'd0);
      chk("reset_busy", {31'd0, busy_o}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (10) @(posedge clk);

      for (int v = 0; v < 11; v++) begin
         set_cfg(vecs[v].dbits, vecs[v].pen, vecs[v].podd, vecs[v].s2);
         valid_hi = 0;
         sb.push_back('{vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr});
         send_frame(vecs[v].data, vecs[v].dbits, vecs[v].pen, vecs[v].podd, vecs[v].s2,
                    vecs[v].pflip, vecs[v].st1, vecs[v].st2);
         repeat (4) @(posedge clk);
         chk("valid_pulse_len", valid_hi, 1);
         chk("frame_consumed", sb.size(), 0);
      end

      // False start: low for 20 clocks only.
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      valid_hi = 0;
      @(posedge clk);
      #1 rx_i = 1'b0;
      repeat (6) @(posedge clk);
      #1 chk("false_start_busy", {31'd0, busy_o}, 32'd1);
      repeat (14) @(posedge clk);
      #1 rx_i = 1'b1;
      repeat (60) @(posedge clk);
      #1 chk("false_start_idle", {31'd0, busy_o}, 32'd0);
      chk("false_start_no_char", valid_hi, 0);
      repeat (BIT) @(posedge clk);

      // Break: line low for 12 bit times gives one character with a framing error.
      valid_hi = 0;
      sb.push_back('{8'h00, 1'b0, 1'b1});
      @(posedge clk);
      #1 rx_i = 1'b0;
      repeat (12 * BIT) @(posedge clk);
      #1 rx_i = 1'b1;
      repeat (2 * BIT) @(posedge clk);
      chk("break_one_char", valid_hi, 1);
      chk("break_consumed", sb.size(), 0);

      // Overrun: hold ready low across two frames.
      @(posedge clk);
      #1 rx_ready_i = 1'b0;
      ovr_cnt = 0;
      sb.push_back('{8'h11, 1'b0, 1'b0});
      send_frame(8'h11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(8'h22, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      chk("overrun_hold_data", {24'd0, rx_data_o}, 32'h11);
      chk("overrun_hold_valid", {31'd0, rx_valid_o}, 32'd1);
      chk("overrun_pulses", ovr_cnt, 1);
      @(posedge clk);
      #1 rx_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("overrun_accepted", sb.size(), 0);
      chk("overrun_valid_clear", {31'd0, rx_valid_o}, 32'd0);

      // Reset while a character is held and a new frame is in its data bits.
      @(posedge clk);
      #1 rx_ready_i = 1'b0;
      set_cfg(2'b00, 1'b0, 1'b0, 1'b1);
      send_frame(8'h15, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      chk("held_5n2_data", {24'd0, rx_data_o}, 32'h15);
      chk("held_5n2_valid", {31'd0, rx_valid_o}, 32'd1);
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      fork
         send_frame(8'h33, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         begin
            repeat (4 * BIT) @(posedge clk);
            #2 chk("pre_reset_busy", {31'd0, busy_o}, 32'd1);
            rst = 1'b0;
            #1;
            chk("rst_data", {24'd0, rx_data_o}, 32'd0);
            chk("rst_valid", {31'd0, rx_valid_o}, 32'd0);
            chk("rst_perr", {31'd0, parity_err_o}, 32'd0);
            chk("rst_ferr", {31'd0, frame_err_o}, 32'd0);
            chk("rst_overrun", {31'd0, overrun_o}, 32'd0);
            chk("rst_busy", {31'd0, busy_o}, 32'd0);
         end
      join
      @(posedge clk);
      #1 rst = 1'b1;
      rx_ready_i = 1'b1;
      valid_hi = 0;
      repeat (3 * BIT) @(posedge clk);
      #1;
      chk("post_reset_no_char", valid_hi, 0);
      chk("post_reset_idle", {31'd0, busy_o}, 32'd0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
